// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus driver: FSM states, command word
// layout, controller timing in ns and the ns-to-cycles conversion.
// Optional build macro: LCD_4BIT_EN (4-bit bus with nibble-split transfers).
package lcd_pkg;

    // Command word layout
    localparam int CMD_W   = 11;
    localparam int DB_LSB  = 0;
    localparam int RW_BIT  = 8;
    localparam int RS_BIT  = 9;
    localparam int NIB_BIT = 10;

    // Controller timing in ns
    localparam longint unsigned T_AS_NS    = 64'd40;
    localparam longint unsigned T_PW_NS    = 64'd230;
    localparam longint unsigned T_H_NS     = 64'd10;
    localparam longint unsigned T_GAP_NS   = 64'd500;
    localparam longint unsigned T_SHORT_NS = 64'd37_000;
    localparam longint unsigned T_LONG_NS  = 64'd1_530_000;
    localparam longint unsigned T_POW_NS   = 64'd15_000_000;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
`ifdef LCD_4BIT_EN
        ST_GAP,
        ST_SETUP2,
        ST_PULSE2,
        ST_HOLD2,
`endif
        ST_EXEC
    } state_t;

    // Clock cycles covering at least ns nanoseconds, never fewer than one
    function automatic int unsigned cycles(input longint unsigned ns,
                                           input longint unsigned clk_hz);
        longint unsigned n;
        n = (ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (n == 64'd0) n = 64'd1;
        return n[31:0];
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with zero flag; it stops at zero until reloaded.
module lcd_delay_counter
    import lcd_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RESET_VALUE;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 character-LCD bus driver: takes one command word per handshake,
// drives RS/RW/DB and a registered E strobe with setup/pulse/hold timing,
// then blocks for the controller execution time.
// Optional build macro: LCD_4BIT_EN (4-bit bus, high nibble then low nibble).
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int CLOCK = 50_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [CMD_W-1:0] i_command,
    output logic             o_ready,
    output logic             o_rs,
    output logic             o_rw,
    output logic [7:0]       o_db,
    output logic             o_e,
    output logic             o_busy
);

    localparam int unsigned TAS    = cycles(T_AS_NS,    64'(CLOCK));
    localparam int unsigned TPW    = cycles(T_PW_NS,    64'(CLOCK));
    localparam int unsigned TH     = cycles(T_H_NS,     64'(CLOCK));
    localparam int unsigned TSHORT = cycles(T_SHORT_NS, 64'(CLOCK));
    localparam int unsigned TLONG  = cycles(T_LONG_NS,  64'(CLOCK));
    localparam int unsigned TPOW   = cycles(T_POW_NS,   64'(CLOCK));
    localparam int          CW     = $clog2(TPOW + 1);

    localparam logic [CW-1:0] TAS_M1    = CW'(TAS - 1);
    localparam logic [CW-1:0] TPW_M1    = CW'(TPW - 1);
    localparam logic [CW-1:0] TH_M1     = CW'(TH - 1);
    localparam logic [CW-1:0] TSHORT_M1 = CW'(TSHORT - 1);
    localparam logic [CW-1:0] TLONG_M1  = CW'(TLONG - 1);
    localparam logic [CW-1:0] TPOW_M1   = CW'(TPOW - 1);
`ifdef LCD_4BIT_EN
    localparam int unsigned   TGAP      = cycles(T_GAP_NS, 64'(CLOCK));
    localparam logic [CW-1:0] TGAP_M1   = CW'(TGAP - 1);
`endif

    state_t           state;
    state_t           state_next;
    logic [CMD_W-1:0] cmd_q;
    logic             is_long;
    logic             load;
    logic [CW-1:0]    load_value;
    logic             zero;
    logic             e_next;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time
    assign is_long = ~cmd_q[RS_BIT] & ~cmd_q[RW_BIT] &
                     (cmd_q[DB_LSB+2 +: 6] == 6'd0);

`ifndef LCD_4BIT_EN
    logic unused_nib;
    assign unused_nib = cmd_q[NIB_BIT];
`endif

    lcd_delay_counter #(
        .WIDTH       (CW),
        .RESET_VALUE (TPOW_M1)
    ) u_delay (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (load),
        .load_value (load_value),
        .zero       (zero)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_POWERUP;
        else
            state <= state_next;
    end

    // Next-state logic: every timed state leaves when the delay hits zero
    always_comb begin
        state_next = state;
        case (state)
            ST_POWERUP: if (zero) state_next = ST_IDLE;
            ST_IDLE:    if (i_valid) state_next = ST_SETUP;
            ST_SETUP:   if (zero) state_next = ST_PULSE;
            ST_PULSE:   if (zero) state_next = ST_HOLD;
`ifdef LCD_4BIT_EN
            ST_HOLD:    if (zero) state_next = cmd_q[NIB_BIT] ? ST_EXEC : ST_GAP;
            ST_GAP:     if (zero) state_next = ST_SETUP2;
            ST_SETUP2:  if (zero) state_next = ST_PULSE2;
            ST_PULSE2:  if (zero) state_next = ST_HOLD2;
            ST_HOLD2:   if (zero) state_next = ST_EXEC;
`else
            ST_HOLD:    if (zero) state_next = ST_EXEC;
`endif
            ST_EXEC:    if (zero) state_next = ST_IDLE;
            default:    state_next = ST_POWERUP;
        endcase
    end

    // Output logic: delay reload on state entry, strobe request, handshake
    always_comb begin
        load       = (state_next != state);
        load_value = '0;
        case (state_next)
            ST_POWERUP: load_value = TPOW_M1;
            ST_SETUP:   load_value = TAS_M1;
            ST_PULSE:   load_value = TPW_M1;
            ST_HOLD:    load_value = TH_M1;
`ifdef LCD_4BIT_EN
            ST_GAP:     load_value = TGAP_M1;
            ST_SETUP2:  load_value = TAS_M1;
            ST_PULSE2:  load_value = TPW_M1;
            ST_HOLD2:   load_value = TH_M1;
`endif
            ST_EXEC:    load_value = is_long ? TLONG_M1 : TSHORT_M1;
            default:    load_value = '0;
        endcase
`ifdef LCD_4BIT_EN
        e_next = (state == ST_PULSE) || (state == ST_PULSE2);
`else
        e_next = (state == ST_PULSE);
`endif
        o_ready = (state == ST_IDLE);
        o_busy  = (state != ST_IDLE);
    end

    // Command latch: only a completed handshake captures the word
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && i_valid)
            cmd_q <= i_command;
    end

    // Registered LCD pins; bus changes only while in a setup state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_e  <= 1'b0;
            o_rs <= 1'b0;
            o_rw <= 1'b0;
            o_db <= 8'h00;
        end else begin
            o_e <= e_next;
            if (state == ST_SETUP) begin
                o_rs <= cmd_q[RS_BIT];
                o_rw <= cmd_q[RW_BIT];
`ifdef LCD_4BIT_EN
                o_db <= {cmd_q[DB_LSB+4 +: 4], 4'h0};
`else
                o_db <= cmd_q[DB_LSB +: 8];
`endif
            end
`ifdef LCD_4BIT_EN
            if (state == ST_SETUP2)
                o_db <= {cmd_q[DB_LSB +: 4], 4'h0};
`endif
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver at CLOCK = 1 MHz
// (TAS=TPW=TH=TGAP=1, TSHORT=37, TLONG=1530, TPOW=15000 cycles).
module tb_lcd_bus_driver;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [10:0] i_command = 11'h000;
    logic        o_ready, o_rs, o_rw, o_e, o_busy;
    logic [7:0]  o_db;

    always #5 i_clk = ~i_clk;

    lcd_bus_driver #(.CLOCK(1_000_000)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_command (i_command),
        .o_ready   (o_ready),
        .o_rs      (o_rs),
        .o_rw      (o_rw),
        .o_db      (o_db),
        .o_e       (o_e),
        .o_busy    (o_busy)
    );

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] db;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t obs_q[$];
    int      checks = 0;
    int      errors = 0;
    int      wide_e = 0;
    logic    prev_e = 1'b0;

    // Bus capture on every rising E; also flag strobes longer than one cycle
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_e <= 1'b0;
        end else begin
            if (o_e && !prev_e) obs_q.push_back({o_rs, o_rw, o_db});
            if (o_e && prev_e) wide_e <= wide_e + 1;
            prev_e <= o_e;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference busy length: setup/pulse/hold per nibble, optional gap, execution
    function automatic int exp_busy(input logic [10:0] c);
        int exec;
        exec = (c[9:8] == 2'b00 && c[7:2] == 6'd0) ? 1530 : 37;
`ifdef LCD_4BIT_EN
        return (c[10] ? 3 : 7) + exec;
`else
        return 3 + exec;
`endif
    endfunction

    function automatic strobe_t first_strobe(input logic [10:0] c);
`ifdef LCD_4BIT_EN
        return {c[9], c[8], c[7:4], 4'h0};
`else
        return {c[9], c[8], c[7:0]};
`endif
    endfunction

    task automatic push_expected(input logic [10:0] c);
        exp_q.push_back(first_strobe(c));
`ifdef LCD_4BIT_EN
        if (!c[10]) exp_q.push_back({c[9], c[8], c[3:0], 4'h0});
`endif
    endtask

    task automatic compare_sb(input string tag);
        strobe_t e, o;
        chk({tag, "_nstrobe"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_strobe"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 20000) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
    endtask

    // Busy cycles from the handshake edge until o_ready is seen again
    task automatic count_busy(input string tag, input logic [10:0] c, output int n);
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            if (n == 1) begin
                chk({tag, "_bus_c1"}, 32'({o_rs, o_rw, o_db}), 32'(first_strobe(c)));
                chk({tag, "_e_c1"}, 32'(o_e), 32'd0);
            end
            if (n == 2) chk({tag, "_e_c2"}, 32'(o_e), 32'd1);
            n++;
            if (n > 20000) break;
        end
    endtask

    task automatic send(input logic [10:0] c, input string tag);
        int n;
        wait_ready(tag);
        i_valid   = 1'b1;
        i_command = c;
        push_expected(c);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        count_busy(tag, c, n);
        chk({tag, "_busy"}, 32'(n), 32'(exp_busy(c)));
        compare_sb(tag);
    endtask

    task automatic powerup(input string tag);
        int n = 0;
        int e_hi = 0;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            if (o_e) e_hi++;
            n++;
            if (n > 20000) break;
        end
        chk({tag, "_len"}, 32'(n), 32'd15000);
        chk({tag, "_e_quiet"}, 32'(e_hi), 32'd0);
    endtask

    initial begin
        int n;
        logic [10:0] a, b;

        // Reset values
        i_rst = 1'b1;
        #23;
        chk("rst_e", 32'(o_e), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd1);
        chk("rst_bus", 32'({o_rs, o_rw, o_db}), 32'd0);
        powerup("pu1");

        // Data write, clear, home, read-type strobe, nibble-only word
        send(11'h241, "wr41");
        send(11'h001, "clear");
        send(11'h002, "home");
        send(11'h1FF, "rw1");
        send(11'h420, "nib");
        send(11'h06C, "wr6c");

        // Valid held high with changing data while busy
        a = 11'h248;
        b = 11'h253;
        wait_ready("b2b");
        i_valid   = 1'b1;
        i_command = a;
        push_expected(a);
        @(posedge i_clk);
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            i_command = 11'($urandom_range(0, 2047));
            n++;
            if (n > 20000) break;
        end
        chk("b2b_a_busy", 32'(n), 32'(exp_busy(a)));
        i_command = b;
        push_expected(b);
        @(posedge i_clk);
        #1 chk("b2b_accept", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            n++;
            if (n > 20000) break;
        end
        chk("b2b_b_busy", 32'(n), 32'(exp_busy(b)));
        compare_sb("b2b");

        // Asynchronous reset while E is high
        wait_ready("arst");
        i_valid   = 1'b1;
        i_command = 11'h241;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        n = 0;
        while (!o_e && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("arst_e_seen", 32'(o_e), 32'd1);
        #2 i_rst = 1'b1;
        #1 chk("arst_e_async", 32'(o_e), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd1);
        repeat (3) @(posedge i_clk);
        exp_q.delete();
        obs_q.delete();
        powerup("pu2");
        send(11'h241, "post_rst");

        chk("e_width", 32'(wide_e), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
